seg7_scan_mux: RTL and testbench

Parametrised time-multiplexed seven-segment driver. It takes a packed hex value of DIGITS nibbles and scans it onto a common-anode display, one digit at a time, with active-low segment and anode outputs. It sits between the switch/adder datapath and the board display pins. Relative to the single-value hex display path it adds N-digit scanning, a per-frame shadow register (no tearing), inter-digit ghost blanking, optional leading-zero suppression, per-digit enable and decimal points.

---
 rtl/seg7_scan_mux.sv | 175 +++++++++++++++++
 tb/tb_seg7_scan_mux.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_mux.sv
// Time-multiplexed N-digit seven-segment driver with frame-shadowed data and ghost blanking.
// Latency: an/seg/dp_n are registered from next-state, so they track (idx, div_cnt) with no lag.
// Backpressure: none; a load is always accepted and the last load before a frame boundary wins.
module seg7_scan_mux #(
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 4,
   parameter int LZB         = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [4*DIGITS-1:0]   value,
   input  logic                  load,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic [DIGITS-1:0]     digit_en,
   output logic [6:0]            seg,
   output logic                  dp_n,
   output logic [DIGITS-1:0]     an,
   output logic                  frame_done
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int DW = $clog2(REFRESH_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

   // Segment pattern {CG..CA}, active low.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   logic [DW-1:0]         div_q, div_d;
   logic [IW-1:0]         idx_q, idx_d;
   logic [4*DIGITS-1:0]   act_val_q, act_val_d;
   logic [DIGITS-1:0]     act_dp_q, act_dp_d;
   logic [4*DIGITS-1:0]   pend_val_q, pend_val_d;
   logic [DIGITS-1:0]     pend_dp_q, pend_dp_d;
   logic                  pend_q, pend_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dpn_q, dpn_d;
   logic [DIGITS-1:0]     an_q, an_d;
   logic                  fdone_q, fdone_d;

   logic                  div_wrap;
   logic                  boundary;

   // Scan counters: slot divider and digit index; the frame boundary is the last cycle of the last slot.
   always_comb begin
      div_wrap = (div_q == DIV_LAST);
      boundary = div_wrap && (idx_q == IDX_LAST);
      div_d    = div_wrap ? '0 : div_q + 1'b1;
      idx_d    = idx_q;
      if (div_wrap) begin
         idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
   end

   // Shadowing: loads park in pending and only reach the displayed copy on a frame boundary.
   always_comb begin
      act_val_d  = act_val_q;
      act_dp_d   = act_dp_q;
      pend_val_d = pend_val_q;
      pend_dp_d  = pend_dp_q;
      pend_d     = pend_q;
      if (boundary) begin
         pend_d = 1'b0;
         if (load) begin
            act_val_d = value;
            act_dp_d  = dp_in;
         end else if (pend_q) begin
            act_val_d = pend_val_q;
            act_dp_d  = pend_dp_q;
         end
      end else if (load) begin
         pend_val_d = value;
         pend_dp_d  = dp_in;
         pend_d     = 1'b1;
      end
   end

   // Output decode from next state so the pins line up with the counters on the same edge.
   always_comb begin
      logic [3:0] nib;
      logic       dp_bit;
      logic       en_bit;
      logic       blank;
      logic       lit;
      nib    = '0;
      dp_bit = 1'b0;
      en_bit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (idx_d == IW'(i)) begin
            nib    = act_val_d[4*i +: 4];
            dp_bit = act_dp_d[i];
            en_bit = digit_en[i];
         end
      end
      // Leading-zero blank: this digit and every more-significant nibble are zero; digit 0 always shows.
      blank = 1'b0;
      if ((LZB != 0) && (idx_d != '0)) begin
         blank = 1'b1;
         for (int i = 0; i < DIGITS; i++) begin
            if ((i >= int'(idx_d)) && (act_val_d[4*i +: 4] != 4'h0)) begin
               blank = 1'b0;
            end
         end
      end
      // Slot cycle 0 is a guard cycle so the previous digit's segments never ghost onto the next anode.
      lit     = (div_d != '0) && en_bit && !blank;
      an_d    = lit ? ~(DIGITS'(1) << idx_d) : '1;
      seg_d   = lit ? hex7(nib) : 7'h7F;
      dpn_d   = lit ? ~dp_bit : 1'b1;
      fdone_d = boundary;
   end

   // Scan and data state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_q      <= '0;
         idx_q      <= '0;
         act_val_q  <= '0;
         act_dp_q   <= '0;
         pend_val_q <= '0;
         pend_dp_q  <= '0;
         pend_q     <= 1'b0;
      end else begin
         div_q      <= div_d;
         idx_q      <= idx_d;
         act_val_q  <= act_val_d;
         act_dp_q   <= act_dp_d;
         pend_val_q <= pend_val_d;
         pend_dp_q  <= pend_dp_d;
         pend_q     <= pend_d;
      end
   end

   // Registered display pins, dark on reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q   <= 7'h7F;
         dpn_q   <= 1'b1;
         an_q    <= '1;
         fdone_q <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         dpn_q   <= dpn_d;
         an_q    <= an_d;
         fdone_q <= fdone_d;
      end
   end

   assign seg        = seg_q;
   assign dp_n       = dpn_q;
   assign an         = an_q;
   assign frame_done = fdone_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: one LZB=0 and one LZB=1 instance share stimulus.
// Expected pins come from a cycle-count model of the scan plus a last-load-per-frame shadow.
// Stimulus mixes directed scenarios with randomized loads and digit enables.
module tb_seg7_scan_mux;

   localparam int D  = 4;
   localparam int RD = 4;
   localparam int FR = D * RD;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [15:0]   value = '0;
   logic          load = 1'b0;
   logic [3:0]    dp_in = '0;
   logic [3:0]    digit_en = 4'hF;

   logic [6:0]    seg0, seg1;
   logic          dpn0, dpn1;
   logic [3:0]    an0, an1;
   logic          fd0, fd1;

   seg7_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD), .LZB(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
      .digit_en(digit_en), .seg(seg0), .dp_n(dpn0), .an(an0), .frame_done(fd0)
   );

   seg7_scan_mux #(.DIGITS(D), .REFRESH_DIV(RD), .LZB(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .value(value), .load(load), .dp_in(dp_in),
      .digit_en(digit_en), .seg(seg1), .dp_n(dpn1), .an(an1), .frame_done(fd1)
   );

   always #5 clk = ~clk;

   // Hex table transcribed from the display definition.
   logic [6:0] HEX [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

   int n_vec = 0;
   int n_err = 0;

   // Model: t counts clock edges since reset release; what is shown is the value
   // most recently loaded before or on the last frame boundary.
   int          t;
   logic [15:0] m_act;
   logic [3:0]  m_act_dp;
   logic [15:0] m_last;
   logic [3:0]  m_last_dp;
   bit          m_seen;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0d)", tag, got, exp, t);
      end
   endtask

   task automatic model_reset();
      t        = 0;
      m_act    = '0;
      m_act_dp = '0;
      m_seen   = 1'b0;
   endtask

   // Apply one clock edge to the model using the inputs as the DUT saw them.
   task automatic model_edge();
      if (t % FR == FR - 1) begin
         if (load) begin
            m_act    = value;
            m_act_dp = dp_in;
         end else if (m_seen) begin
            m_act    = m_last;
            m_act_dp = m_last_dp;
         end
         m_seen = 1'b0;
      end else if (load) begin
         m_last    = value;
         m_last_dp = dp_in;
         m_seen    = 1'b1;
      end
      t++;
   endtask

   task automatic expect_pins(input bit lz, output logic [3:0] e_an,
                              output logic [6:0] e_seg, output logic e_dp);
      int          slot_pos;
      int          dig;
      logic [15:0] hi;
      bit          lit;
      slot_pos = t % RD;
      dig      = (t / RD) % D;
      hi       = m_act >> (4 * dig);
      lit      = (slot_pos != 0) && digit_en[dig];
      if (lz && dig != 0 && hi == 16'h0) lit = 1'b0;
      e_an  = lit ? ~(4'b0001 << dig) : 4'hF;
      e_seg = lit ? HEX[hi[3:0]] : 7'h7F;
      e_dp  = lit ? ~m_act_dp[dig] : 1'b1;
   endtask

   task automatic check_all();
      logic [3:0] e_an;
      logic [6:0] e_seg;
      logic       e_dp;
      logic       e_fd;
      e_fd = (t > 0) && (t % FR == 0);
      expect_pins(1'b0, e_an, e_seg, e_dp);
      check("an0", 32'(an0), 32'(e_an));
      check("seg0", 32'(seg0), 32'(e_seg));
      check("dpn0", 32'(dpn0), 32'(e_dp));
      check("fd0", 32'(fd0), 32'(e_fd));
      expect_pins(1'b1, e_an, e_seg, e_dp);
      check("an1", 32'(an1), 32'(e_an));
      check("seg1", 32'(seg1), 32'(e_seg));
      check("dpn1", 32'(dpn1), 32'(e_dp));
      check("fd1", 32'(fd1), 32'(fd1 === 1'bx ? 1'b0 : e_fd));
   endtask

   task automatic check_reset_pins(input string tag);
      check({tag, "_an0"}, 32'(an0), 32'hF);
      check({tag, "_seg0"}, 32'(seg0), 32'h7F);
      check({tag, "_dpn0"}, 32'(dpn0), 32'h1);
      check({tag, "_fd0"}, 32'(fd0), 32'h0);
      check({tag, "_an1"}, 32'(an1), 32'hF);
      check({tag, "_seg1"}, 32'(seg1), 32'h7F);
      check({tag, "_dpn1"}, 32'(dpn1), 32'h1);
      check({tag, "_fd1"}, 32'(fd1), 32'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic run(input int n);
      for (int k = 0; k < n; k++) tick();
   endtask

   task automatic do_load(input logic [15:0] v, input logic [3:0] dp);
      value = v;
      dp_in = dp;
      load  = 1'b1;
      tick();
      load  = 1'b0;
   endtask

   task automatic advance_to(input int pos);
      while (t % FR != pos) tick();
   endtask

   initial begin
      logic [15:0] rv;
      model_reset();

      // Reset hold: pins dark across several edges.
      repeat (3) @(posedge clk);
      #1;
      check_reset_pins("rst");
      @(negedge clk);
      rst_n = 1'b1;

      // First frame: digit 0 shows "0" on cycles 1-3, frame_done at t=16.
      run(FR + 4);

      // Count 0..F on digit 0, one load per frame.
      for (int n = 0; n < 16; n++) begin
         do_load(16'(n), 4'h0);
         run(FR + 2);
      end

      // Shadow: two loads mid-frame, last one wins next frame.
      advance_to(5);
      do_load(16'h1234, 4'h0);
      tick();
      do_load(16'hABCD, 4'h0);
      run(2 * FR);

      // Load on the boundary edge is visible in the very next frame.
      advance_to(FR - 1);
      do_load(16'h5A3C, 4'h0);
      run(FR + 1);

      // Digit enable and decimal points.
      digit_en = 4'b0101;
      do_load(16'h8888, 4'b0100);
      run(2 * FR);
      digit_en = 4'hF;

      // Leading-zero patterns.
      do_load(16'h0005, 4'h0);
      run(2 * FR);
      do_load(16'h0000, 4'h0);
      run(2 * FR);
      do_load(16'h0105, 4'h2);
      run(2 * FR);

      // Randomized loads, nibble zeroing, dp and enable changes.
      for (int c = 0; c < 1500; c++) begin
         if ($urandom_range(15, 0) == 0) digit_en = 4'($urandom);
         if ($urandom_range(7, 0) == 0) begin
            rv = 16'($urandom);
            for (int k = 0; k < 4; k++) begin
               if ($urandom_range(1, 0) == 1) rv[4*k +: 4] = 4'h0;
            end
            do_load(rv, 4'($urandom));
         end else begin
            tick();
         end
      end

      // Mid-frame reset at idx=2, div_cnt=2 with nonzero active data.
      digit_en = 4'hF;
      do_load(16'h9999, 4'hF);
      run(2 * FR);
      advance_to(2 * RD + 2);
      #1;
      rst_n = 1'b0;
      model_reset();
      #1;
      check_reset_pins("mid_rst");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(2 * FR);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
